// File: rtl/hop_cnt_rr_allocator.sv
// Output-port allocator for one mesh switch output: starved inputs first, then highest hop count, then round-robin.
// Latency: grant registered 1 cycle after arbitration in IDLE; at least 1 idle cycle between packets.
// Backpressure: the grant is held across out_rdy_i low and request bubbles; it is released only on the tail transfer.
module hop_cnt_rr_allocator #(
  parameter int IN_N      = 5,
  parameter int HOP_CNT_W = 3,
  parameter int AGE_W     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [IN_N-1:0]              req_i,
  input  logic [IN_N*HOP_CNT_W-1:0]    hop_cnt_i,
  input  logic [IN_N-1:0]              tail_i,
  input  logic                         out_rdy_i,
  output logic [IN_N-1:0]              grant_o,
  output logic [$clog2(IN_N)-1:0]      grant_idx_o,
  output logic                         grant_vld_o,
  output logic                         xfer_o,
  output logic                         tie_o
);

  localparam int IDX_W = $clog2(IN_N);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q;
  logic [IN_N-1:0]      grant_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic                 grant_vld_q;
  logic                 tie_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [AGE_W-1:0]     age_q [IN_N];

  logic [HOP_CNT_W-1:0] max_hop;
  logic [IN_N-1:0]      starved;
  logic [IN_N-1:0]      top_hop;
  logic [IN_N-1:0]      cand;
  logic [IN_N-1:0]      win_oh_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic                 win_found;
  logic                 tie_d;
  logic                 cand_seen;
  logic [IDX_W:0]       scan_sum;
  logic [IDX_W-1:0]     scan_idx;
  logic                 sel_req;
  logic                 sel_tail;

  // Build the candidate set (starved requesters override hop-count priority) and flag ties.
  always_comb begin
    max_hop   = '0;
    starved   = '0;
    top_hop   = '0;
    tie_d     = 1'b0;
    cand_seen = 1'b0;
    for (int k = 0; k < IN_N; k++) begin
      if (req_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] > max_hop)) begin
        max_hop = hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W];
      end
    end
    for (int k = 0; k < IN_N; k++) begin
      starved[k] = req_i[k] && (age_q[k] == AGE_MAX);
      top_hop[k] = req_i[k] && (hop_cnt_i[k*HOP_CNT_W +: HOP_CNT_W] == max_hop);
    end
    cand = (|starved) ? starved : top_hop;
    for (int k = 0; k < IN_N; k++) begin
      if (cand[k]) begin
        if (cand_seen) tie_d = 1'b1;
        cand_seen = 1'b1;
      end
    end
  end

  // Pick the first candidate at or after the rr pointer; wrap by explicit compare so non-power-of-two IN_N works.
  always_comb begin
    win_oh_d  = '0;
    win_idx_d = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < IN_N; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (scan_sum > (IDX_W+1)'(IN_N-1)) scan_sum = scan_sum - (IDX_W+1)'(IN_N);
      scan_idx = scan_sum[IDX_W-1:0];
      if (!win_found && cand[scan_idx]) begin
        win_found          = 1'b1;
        win_idx_d          = scan_idx;
        win_oh_d[scan_idx] = 1'b1;
      end
    end
  end

  // The one-hot grant selects the granted input's request and tail bits without a variable index.
  always_comb begin
    sel_req  = |(req_i & grant_q);
    sel_tail = |(tail_i & grant_q);
  end

  assign xfer_o      = grant_vld_q & sel_req & out_rdy_i;
  assign grant_o     = grant_q;
  assign grant_idx_o = grant_idx_q;
  assign grant_vld_o = grant_vld_q;
  assign tie_o       = tie_q;

  // Allocation FSM: arbitrate and age in IDLE, hold the grant in BUSY until the tail flit transfers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      tie_q       <= 1'b0;
      rr_ptr_q    <= '0;
      for (int k = 0; k < IN_N; k++) age_q[k] <= '0;
    end else begin
      tie_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_i) begin
            grant_q     <= win_oh_d;
            grant_idx_q <= win_idx_d;
            grant_vld_q <= 1'b1;
            tie_q       <= tie_d;
            state_q     <= BUSY;
            for (int k = 0; k < IN_N; k++) begin
              if (req_i[k]) begin
                if (win_oh_d[k])             age_q[k] <= '0;
                else if (age_q[k] != AGE_MAX) age_q[k] <= age_q[k] + AGE_W'(1);
              end
            end
          end
        end
        BUSY: begin
          if (xfer_o && sel_tail) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_vld_q <= 1'b0;
            rr_ptr_q    <= (grant_idx_q == IDX_W'(IN_N-1)) ? '0 : grant_idx_q + IDX_W'(1);
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hop_cnt_rr_allocator.sv
module tb_hop_cnt_rr_allocator;

  logic        clk;
  logic        rst;
  logic [4:0]  req;
  logic [14:0] hop;
  logic [4:0]  tail;
  logic        rdy;

  logic [4:0]  g0, g1;
  logic [2:0]  gi0, gi1;
  logic        gv0, gv1, x0, x1, t0, t1;

  int total = 0;
  int bad   = 0;
  int xcnt;

  hop_cnt_rr_allocator u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .hop_cnt_i(hop), .tail_i(tail), .out_rdy_i(rdy),
    .grant_o(g0), .grant_idx_o(gi0), .grant_vld_o(gv0), .xfer_o(x0), .tie_o(t0)
  );

  hop_cnt_rr_allocator #(.IN_N(5), .HOP_CNT_W(3), .AGE_W(2)) u_age (
    .clk_i(clk), .rst_i(rst), .req_i(req), .hop_cnt_i(hop), .tail_i(tail), .out_rdy_i(rdy),
    .grant_o(g1), .grant_idx_o(gi1), .grant_vld_o(gv1), .xfer_o(x1), .tie_o(t1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tail = '0; rdy = 1'b0; hop = '0;
    tick();
    rst = 1'b0;
  endtask

  logic [4:0] s4_req  [8] = '{5'b00110, 5'b00110, 5'b00100, 5'b00100, 5'b00110, 5'b00110, 5'b00110, 5'b00110};
  logic       s4_rdy  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [4:0] s4_tail [8] = '{5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b00010};
  logic       s4_x    [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [2:0] s5_idx  [8] = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd4, 3'd4, 3'd4, 3'd0};

  initial begin
    // Reset with all inputs requesting: everything idle, no transfer.
    rst = 1'b1; req = 5'b11111; hop = '0; tail = '0; rdy = 1'b1;
    #3;
    chk("rst_grant", g0, 0);
    chk("rst_idx", gi0, 0);
    chk("rst_vld", gv0, 0);
    chk("rst_tie", t0, 0);
    chk("rst_xfer", x0, 0);
    tick();
    chk("rst_vld_edge", gv0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_vld", gv0, 1);
    chk("post_rst_grant", g0, 5'b00001);
    chk("post_rst_tie", t0, 1);
    tail = 5'b11111;
    #1;
    chk("post_rst_xfer", x0, 1);
    tick();
    chk("post_rst_release", gv0, 0);
    chk("post_rst_tie_pulse", t0, 0);
    req = '0;

    // Max hop count wins.
    do_reset();
    req = 5'b10110; hop = {3'd3, 3'd0, 3'd5, 3'd2, 3'd0};
    tick();
    chk("maxhop_grant", g0, 5'b00100);
    chk("maxhop_idx", gi0, 2);
    chk("maxhop_tie", t0, 0);
    chk("maxhop_vld", gv0, 1);
    tail = 5'b11111; rdy = 1'b1;
    #1;
    chk("maxhop_xfer", x0, 1);
    tick();
    chk("maxhop_release", gv0, 0);
    req = '0;

    // Tie between in0 and in3, rotating by round robin with an idle gap.
    do_reset();
    req = 5'b01001; hop = {3'd0, 3'd4, 3'd0, 3'd0, 3'd4}; tail = 5'b11111; rdy = 1'b1;
    tick();
    chk("rr1_grant", g0, 5'b00001);
    chk("rr1_tie", t0, 1);
    tick();
    chk("rr1_gap", gv0, 0);
    tick();
    chk("rr2_grant", g0, 5'b01000);
    chk("rr2_idx", gi0, 3);
    chk("rr2_tie", t0, 1);
    tick();
    chk("rr2_gap", gv0, 0);
    tick();
    chk("rr3_grant", g0, 5'b00001);
    chk("rr3_tie", t0, 1);
    tick();
    chk("rr3_gap", gv0, 0);
    req = '0;

    // Hold under backpressure and request bubbles; in2 with hop 7 must wait.
    do_reset();
    req = 5'b00010; hop = {3'd0, 3'd0, 3'd7, 3'd1, 3'd0}; tail = '0; rdy = 1'b0;
    tick();
    chk("hold_grant", g0, 5'b00010);
    xcnt = 0;
    for (int c = 0; c < 8; c++) begin
      req = s4_req[c]; rdy = s4_rdy[c]; tail = s4_tail[c];
      #1;
      chk($sformatf("hold_xfer_c%0d", c), x0, s4_x[c]);
      chk($sformatf("hold_grant_c%0d", c), g0, 5'b00010);
      if (x0) xcnt++;
      tick();
    end
    chk("hold_xfer_count", xcnt, 4);
    chk("hold_release", gv0, 0);
    tick();
    chk("hold_next_idx", gi0, 2);
    chk("hold_next_tie", t0, 0);
    tail = 5'b00100; rdy = 1'b1;
    tick();
    chk("hold_next_release", gv0, 0);
    req = '0;

    // Starvation: in0 (hop 1) vs a stream of hop-6 packets from in4.
    do_reset();
    req = 5'b10001; hop = {3'd6, 3'd0, 3'd0, 3'd0, 3'd1}; tail = 5'b11111; rdy = 1'b1;
    for (int a = 0; a < 8; a++) begin
      tick();
      chk($sformatf("starve_age_idx_a%0d", a), gi1, s5_idx[a]);
      chk($sformatf("starve_age_vld_a%0d", a), gv1, 1);
      chk($sformatf("starve_age_tie_a%0d", a), t1, 0);
      chk($sformatf("starve_dflt_idx_a%0d", a), gi0, 4);
      chk($sformatf("starve_age_xfer_a%0d", a), x1, 1);
      tick();
      chk($sformatf("starve_age_gap_a%0d", a), g1, 0);
    end
    req = '0;

    // Reset mid-packet: grant drops immediately and the pointer returns to 0.
    do_reset();
    req = 5'b00001; tail = 5'b11111; rdy = 1'b1;
    tick();
    chk("mid_pre_grant", g0, 5'b00001);
    tick();
    req = 5'b01000; tail = '0;
    tick();
    chk("mid_busy_idx", gi0, 3);
    #1;
    chk("mid_busy_xfer", x0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_grant", g0, 0);
    chk("mid_rst_vld", gv0, 0);
    chk("mid_rst_idx", gi0, 0);
    chk("mid_rst_xfer", x0, 0);
    tick();
    chk("mid_rst_hold_vld", gv0, 0);
    rst = 1'b0;
    req = 5'b01001; hop = {3'd0, 3'd2, 3'd0, 3'd0, 3'd2};
    tick();
    chk("mid_rearb_grant", g0, 5'b00001);
    chk("mid_rearb_tie", t0, 1);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hop_cnt_rr_allocator.md
Name: hop_cnt_rr_allocator

Overview:
- Sequential output-port allocator for one output of a mesh switch.
- Selects one of IN_N requesting inputs each arbitration round, with priority in this order:
  1. starved requesters;
  2. the highest hop count among requesters;
  3. round-robin among ties.
- Holds the grant for the whole wormhole packet until the tail flit transfers.
- Sits between the input-buffer request lines and the output crossbar mux select.

Parameters:
- IN_N, 5, number of switch inputs (supported range 2..8).
- HOP_CNT_W, 3, width of each hop count field.
- AGE_W, 4, width of the per-input starvation counter; AGE_MAX = 2^AGE_W - 1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- req_i  input  IN_N  per-input request; head or body flit present for this output.
- hop_cnt_i  input  IN_N*HOP_CNT_W  packed hop counts; input k occupies bits [k*HOP_CNT_W +: HOP_CNT_W].
- tail_i  input  IN_N  flit currently presented by input k is a tail flit.
- out_rdy_i  input  1  downstream is able to accept a flit this cycle.
- grant_o  output  IN_N  one-hot grant; all zero when idle.
- grant_idx_o  output  $clog2(IN_N)  index of the granted input; 0 when idle.
- grant_vld_o  output  1  a grant is held.
- xfer_o  output  1  a flit transfers this cycle = grant_vld_o & req_i[grant_idx_o] & out_rdy_i (combinational).
- tie_o  output  1  one-cycle pulse; the last arbitration had ≥2 candidates at the winning priority level.

Behaviour:
- Reset (asynchronous, active-high):
  - grant_o = 0, grant_idx_o = 0, grant_vld_o = 0, tie_o = 0.
  - rr pointer = 0, all age counters = 0, FSM = IDLE.
  - Reset asserted mid-packet drops the grant immediately; no transfer is reported while rst_i is high.
- FSM states: IDLE and BUSY.
- IDLE, no req_i bit set: remain in IDLE; outputs stay at their idle values.
- IDLE, any req_i bit set: arbitrate combinationally and register the result. On the next edge:
  - grant_o, grant_idx_o and grant_vld_o = 1 are loaded, and the FSM moves to BUSY.
  - Grant latency is 1 cycle from request to grant_vld_o.
- Arbitration (only among inputs with req_i = 1):
  1. Starved set = inputs whose age == AGE_MAX. If the starved set is non-empty, it is the candidate set.
  2. Otherwise the candidate set = requesters whose hop count equals the maximum hop count among requesters. Hop-count comparison is unsigned.
  3. The winner is the first candidate at or after the rr pointer, scanning upward and wrapping from IN_N-1 to 0.
  4. tie_o is registered high for one cycle when the candidate set holds ≥2 inputs.
- Aging, evaluated at each arbitration in IDLE:
  - Every requesting non-winner increments its age, saturating at AGE_MAX.
  - The winner's age clears to 0.
  - Non-requesters keep their age.
  - Ages do not change in BUSY.
- BUSY:
  - The grant is held regardless of changes on other req_i bits.
  - If req_i[grant_idx_o] drops (bubble), the grant is still held and xfer_o = 0.
  - If out_rdy_i = 0, the grant is held and xfer_o = 0.
- Release: when xfer_o = 1 and tail_i[grant_idx_o] = 1:
  - On that edge, clear grant_o, grant_idx_o and grant_vld_o, and return to IDLE.
  - Set rr pointer = grant_idx_o + 1 (wraps to 0 after IN_N-1).
  - The next grant can appear at the earliest 2 cycles after the tail transfer: 1 idle cycle for arbitration, then the registered grant. There is no back-to-back grant.
- Single-flit packet (head = tail): released on its first transfer.
- Simultaneous events: a tail transfer and new requests in the same cycle are not arbitrated in that cycle; arbitration happens in the following IDLE cycle using the updated pointer.
- Width rule: if IN_N is not a power of two, wrapping uses an explicit compare to IN_N-1, not natural overflow.

Test Plan:
- Reset with req_i = 5'b11111 → all outputs 0 while rst_i = 1. After release, grant_vld_o = 1 one cycle later.
- Max hop wins: req_i = 5'b10110, hop counts {in1 = 2, in2 = 5, in4 = 3} → grant_o = 5'b00100, grant_idx_o = 2, tie_o = 0.
- Tie with round-robin rotation: in0 and in3 request with hop = 4 each, tail_i = 1 on every flit, out_rdy_i = 1, pointer starts at 0. Required response:
  - grant sequence is in0, in3, in0, …;
  - tie_o pulses after each arbitration;
  - grant_vld_o is low for 1 cycle between grants.
- Hold and backpressure: grant in1 for a 4-flit packet; toggle out_rdy_i and drop req_i[1] for 2 cycles; raise in2 with hop = 7. Required response:
  - grant stays at in1;
  - xfer_o pulses exactly 4 times;
  - release happens only on the tail transfer.
- Starvation (AGE_W = 2, AGE_MAX = 3): in0 with hop = 1 competes against a stream of hop = 6 packets from in4. Required response:
  - in0 loses 3 arbitrations;
  - in0 wins the 4th arbitration despite its lower hop count;
  - in0's age returns to 0.
- Reset mid-packet: assert rst_i while in BUSY on in3 → grant_o = 0 immediately (asynchronous), pointer = 0, and the FSM re-arbitrates from IDLE after rst_i deasserts.
